// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Two-register execution stage around a 32-bit integer ALU, sitting
//   between issue and writeback. Operations enter on a valid/ready channel
//   and come out on a second valid/ready channel. One operation per cycle
//   flows through when the consumer keeps up. Up to two operations are held
//   when the consumer stalls.
//
//   S1 captures {op, lhs, rhs, tag}.
//   S2 captures {res, flags, tag}, computed combinationally from S1.
//   All outputs come straight from S2 registers.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset, clears both stages
//   in_valid   request valid
//   in_ready   stage can take a request this cycle (independent of in_valid)
//   in_op      4-bit operation code
//   in_lhs     32-bit left operand
//   in_rhs     32-bit right operand; shifts use rhs[4:0]
//   in_tag     opaque tag, carried through unchanged
//   out_valid  result valid; held with stable data until out_ready
//   out_ready  consumer takes the result this cycle
//   out_res    32-bit result
//   out_flags  {ZF, SF, CF, OF}
//   out_tag    tag of the returned operation
module alu_exec_stage #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_lhs,
    input  logic [31:0]      in_rhs,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_ADDU = 4'b1010;
    localparam logic [3:0] OP_SUBU = 4'b1011;

    logic             s1_valid_q;
    logic [3:0]       s1_op_q;
    logic [31:0]      s1_lhs_q;
    logic [31:0]      s1_rhs_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q;
    logic [31:0]      s2_res_q;
    logic [3:0]       s2_flags_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic             s2_load;
    logic [31:0]      res_d;
    logic [3:0]       flags_d;
    logic             cf_d;
    logic             of_d;
    logic [32:0]      sum_c;
    logic [32:0]      diff_c;
    logic [4:0]       shamt;

    // S2 can take new data when it is empty or its result leaves this cycle.
    // S1 can take new data when it is empty or it moves into S2 this cycle.
    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;

    always_comb begin
        shamt  = s1_rhs_q[4:0];
        sum_c  = {1'b0, s1_lhs_q} + {1'b0, s1_rhs_q};
        // Bit 32 of the zero-extended difference is the unsigned borrow.
        diff_c = {1'b0, s1_lhs_q} - {1'b0, s1_rhs_q};
        res_d  = '0;
        cf_d   = 1'b0;
        of_d   = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                res_d = sum_c[31:0];
                cf_d  = sum_c[32];
                of_d  = (s1_lhs_q[31] == s1_rhs_q[31]) && (res_d[31] != s1_lhs_q[31]);
            end
            OP_ADDU: begin
                res_d = sum_c[31:0];
                cf_d  = sum_c[32];
            end
            OP_SUB: begin
                res_d = diff_c[31:0];
                cf_d  = diff_c[32];
                of_d  = (s1_lhs_q[31] != s1_rhs_q[31]) && (res_d[31] != s1_lhs_q[31]);
            end
            OP_SUBU: begin
                res_d = diff_c[31:0];
                cf_d  = diff_c[32];
            end
            OP_SLL:  res_d = s1_lhs_q << shamt;
            OP_SRL:  res_d = s1_lhs_q >> shamt;
            OP_SRA:  res_d = $unsigned($signed(s1_lhs_q) >>> shamt);
            OP_SLT:  res_d = {31'b0, ($signed(s1_lhs_q) < $signed(s1_rhs_q))};
            OP_SLTU: res_d = {31'b0, (s1_lhs_q < s1_rhs_q)};
            OP_XOR:  res_d = s1_lhs_q ^ s1_rhs_q;
            OP_OR:   res_d = s1_lhs_q | s1_rhs_q;
            OP_AND:  res_d = s1_lhs_q & s1_rhs_q;
            default: res_d = '0;  // reserved codes yield zero
        endcase
        flags_d = {(res_d == 32'd0), res_d[31], cf_d, of_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_lhs_q   <= '0;
            s1_rhs_q   <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_flags_q <= '0;
            s2_tag_q   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_op_q  <= in_op;
                    s1_lhs_q <= in_lhs;
                    s1_rhs_q <= in_rhs;
                    s1_tag_q <= in_tag;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_res_q   <= res_d;
                    s2_flags_q <= flags_d;
                    s2_tag_q   <= s1_tag_q;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_flags = s2_flags_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage. Expected results are pushed to a
// scoreboard queue when a request is accepted and popped when the stage
// hands a result over. Inputs change 1 time unit after the rising edge and
// handshakes are sampled on the falling edge.
module tb_alu_exec_stage;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [31:0]      in_lhs;
    logic [31:0]      in_rhs;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_res;
    logic [3:0]       out_flags;
    logic [TAG_W-1:0] out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0]      res;
        logic [3:0]       flags;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    // Directed vectors with hand-derived results, flags = {ZF,SF,CF,OF}.
    vec_t vecs [23] = '{
        '{4'h0, 32'hffffffff, 32'h00000001, 32'h00000000, 4'b1010},
        '{4'h0, 32'h7fffffff, 32'h10000003, 32'h90000002, 4'b0101},
        '{4'ha, 32'h7fffffff, 32'h10000003, 32'h90000002, 4'b0100},
        '{4'h8, 32'h80000000, 32'h0fffffff, 32'h70000001, 4'b0001},
        '{4'h8, 32'h00000001, 32'h00000002, 32'hffffffff, 4'b0110},
        '{4'hb, 32'h00000001, 32'h00000002, 32'hffffffff, 4'b0110},
        '{4'h1, 32'h000f0000, 32'h00000002, 32'h003c0000, 4'b0000},
        '{4'h9, 32'hffffffff, 32'h00000003, 32'hffffffff, 4'b0100},
        '{4'h9, 32'h000000f0, 32'h00000001, 32'h00000078, 4'b0000},
        '{4'h2, 32'hffff0000, 32'h00030001, 32'h00000001, 4'b0000},
        '{4'h3, 32'hf0000000, 32'h00000001, 32'h00000000, 4'b1000},
        '{4'hf, 32'h12345678, 32'h9abcdef0, 32'h00000000, 4'b1000},
        '{4'h5, 32'h80000000, 32'h00000024, 32'h08000000, 4'b0000},
        '{4'h4, 32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 4'b0000},
        '{4'h6, 32'h00000000, 32'h00000000, 32'h00000000, 4'b1000},
        '{4'h7, 32'hffff0000, 32'h00ffff00, 32'h00ff0000, 4'b0000},
        '{4'h0, 32'h80000000, 32'h80000000, 32'h00000000, 4'b1011},
        '{4'hc, 32'h00000001, 32'h00000001, 32'h00000000, 4'b1000},
        '{4'h1, 32'h00000001, 32'h00000023, 32'h00000008, 4'b0000},
        '{4'h2, 32'h00000005, 32'hffffffff, 32'h00000000, 4'b1000},
        '{4'h3, 32'h00000001, 32'hf0000000, 32'h00000001, 4'b0000},
        '{4'h8, 32'h7fffffff, 32'hffffffff, 32'h80000000, 4'b0111},
        '{4'h0, 32'h00000001, 32'h00000002, 32'h00000003, 4'b0000}
    };

    alu_exec_stage #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_lhs    (in_lhs),
        .in_rhs    (in_rhs),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Reference model using 64-bit arithmetic: overflow means the exact
    // signed result differs from the sign-extended wrapped result.
    function automatic logic [35:0] exp_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      ua;
        longint      ub;
        longint      sa;
        longint      sb;
        longint      exact;
        logic [31:0] r;
        bit          cf;
        bit          of;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'd0;
        cf = 1'b0;
        of = 1'b0;
        case (op)
            4'h0, 4'ha: begin
                exact = ua + ub;
                r     = exact[31:0];
                cf    = (exact > 64'd4294967295);
                if (op == 4'h0) of = ((sa + sb) != longint'($signed(r)));
            end
            4'h8, 4'hb: begin
                exact = ua - ub;
                r     = exact[31:0];
                cf    = (ua < ub);
                if (op == 4'h8) of = ((sa - sb) != longint'($signed(r)));
            end
            4'h1: r = a << b[4:0];
            4'h5: r = a >> b[4:0];
            4'h9: begin
                exact = sa >>> b[4:0];
                r     = exact[31:0];
            end
            4'h2: r = (sa < sb) ? 32'd1 : 32'd0;
            4'h3: r = (ua < ub) ? 32'd1 : 32'd0;
            4'h4: r = a ^ b;
            4'h6: r = a | b;
            4'h7: r = a & b;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r[31], cf, of, r};
    endfunction

    task automatic drive_in(input bit v, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] t);
        in_valid = v;
        in_op    = op;
        in_lhs   = a;
        in_rhs   = b;
        in_tag   = t;
    endtask

    task automatic push_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [TAG_W-1:0] t);
        logic [35:0] m;
        exp_t        e;
        m       = exp_model(op, a, b);
        e.res   = m[31:0];
        e.flags = m[35:32];
        e.tag   = t;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        drive_in(1'b0, 4'h0, 32'h0, 32'h0, '0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (out_res !== 32'h0 || out_flags !== 4'h0 || out_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_out_data: got res=%h flags=%b tag=%h expected all zero",
                     out_res, out_flags, out_tag);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    // One op at a time: checks result, flags, tag and the exact latency.
    task automatic test_alu_ops();
        exp_t e;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 23; i++) begin
            drive_in(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, i[TAG_W-1:0]);
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL ops_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            e.res   = vecs[i].res;
            e.flags = vecs[i].fl;
            e.tag   = i[TAG_W-1:0];
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ops_early_valid[%0d]: got %b expected 0 one edge after accept",
                         i, out_valid);
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || out_res !== e.res || out_flags !== e.flags ||
                out_tag !== e.tag) begin
                n_fail++;
                $display("FAIL ops_result[%0d] op=%h: got v=%b res=%h flags=%b tag=%h expected v=1 res=%h flags=%b tag=%h",
                         i, vecs[i].op, out_valid, out_res, out_flags, out_tag,
                         e.res, e.flags, e.tag);
            end else begin
                $display("op %h %h,%h -> res=%h flags=%b tag=%h", vecs[i].op, vecs[i].a,
                         vecs[i].b, out_res, out_flags, out_tag);
            end
        end
    endtask

    // Eight back-to-back random ops with the consumer always ready.
    task automatic test_back_to_back();
        int          sent = 0;
        int          got = 0;
        int          first_cyc = -1;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        op = 4'($urandom_range(0, 15));
        a  = $urandom;
        b  = $urandom;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if (sent < 8) drive_in(1'b1, op, a, b, sent[TAG_W-1:0]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected: got tag=%h expected no output", out_tag);
                end else begin
                    e = sb_q.pop_front();
                    if (out_res !== e.res || out_flags !== e.flags || out_tag !== e.tag) begin
                        n_fail++;
                        $display("FAIL b2b_result: got res=%h flags=%b tag=%h expected res=%h flags=%b tag=%h",
                                 out_res, out_flags, out_tag, e.res, e.flags, e.tag);
                    end else begin
                        $display("b2b tag=%h res=%h flags=%b", out_tag, out_res, out_flags);
                    end
                end
                if (got == 0) begin
                    first_cyc = cyc;
                end else begin
                    n_checks++;
                    if (cyc != first_cyc + got) begin
                        n_fail++;
                        $display("FAIL b2b_gap: got result %0d at cycle %0d expected cycle %0d",
                                 got, cyc, first_cyc + got);
                    end
                end
                got++;
            end
            if (in_valid) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
                end
                if (in_ready) begin
                    push_model(op, a, b, sent[TAG_W-1:0]);
                    sent++;
                    op = 4'($urandom_range(0, 15));
                    a  = $urandom;
                    b  = $urandom;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 8 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results (%0d pending) expected 8 (0 pending)",
                     got, sb_q.size());
        end
    endtask

    // Consumer stalls: two ops held, in_ready low, outputs frozen, then release.
    task automatic test_stall();
        int               sent = 0;
        int               got = 0;
        logic [3:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      held_res;
        logic [3:0]       held_flags;
        logic [TAG_W-1:0] held_tag;
        exp_t             e;
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        held_res   = '0;
        held_flags = '0;
        held_tag   = '0;
        op = 4'($urandom_range(0, 11));
        a  = $urandom;
        b  = $urandom;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            out_ready = (cyc >= 6);
            if (sent < 5) drive_in(1'b1, op, a, b, 4'(8 + sent));
            else in_valid = 1'b0;
            @(negedge clk);
            if (cyc == 2) begin
                n_checks++;
                if (sent != 2 || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_full: got accepts=%0d in_ready=%b expected accepts=2 in_ready=0",
                             sent, in_ready);
                end
                held_res   = out_res;
                held_flags = out_flags;
                held_tag   = out_tag;
            end
            if (cyc >= 3 && cyc <= 5) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_res !== held_res || out_flags !== held_flags ||
                    out_tag !== held_tag) begin
                    n_fail++;
                    $display("FAIL stall_stable: got v=%b res=%h flags=%b tag=%h expected v=1 res=%h flags=%b tag=%h",
                             out_valid, out_res, out_flags, out_tag, held_res, held_flags, held_tag);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stall_unexpected: got tag=%h expected no output", out_tag);
                end else begin
                    e = sb_q.pop_front();
                    if (out_res !== e.res || out_flags !== e.flags || out_tag !== e.tag) begin
                        n_fail++;
                        $display("FAIL stall_result: got res=%h flags=%b tag=%h expected res=%h flags=%b tag=%h",
                                 out_res, out_flags, out_tag, e.res, e.flags, e.tag);
                    end else begin
                        $display("stall tag=%h res=%h flags=%b", out_tag, out_res, out_flags);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                push_model(op, a, b, 4'(8 + sent));
                sent++;
                op = 4'($urandom_range(0, 11));
                a  = $urandom;
                b  = $urandom;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 5 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results (%0d pending) expected 5 (0 pending)",
                     got, sb_q.size());
        end
    endtask

    // Reset mid-cycle with both stages full, then confirm a clean restart.
    task automatic test_async_reset();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive_in(1'b1, 4'h0, 32'h11, 32'h22, 4'h1);
        @(posedge clk);
        #1;
        drive_in(1'b1, 4'h4, 32'h33, 32'h44, 4'h2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_prefill: got out_valid=%b in_ready=%b expected 1 and 0",
                     out_valid, in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_res !== 32'h0 || out_flags !== 4'h0 || out_tag !== '0) begin
            n_fail++;
            $display("FAIL arst_immediate: got v=%b res=%h flags=%b tag=%h expected all zero",
                     out_valid, out_res, out_flags, out_tag);
        end
        sb_q.delete();
        @(posedge clk);
        #3;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL arst_stale[%0d]: got out_valid=%b tag=%h expected 0", c,
                         out_valid, out_tag);
            end
        end
        @(posedge clk);
        #1;
        drive_in(1'b1, 4'h8, 32'h5, 32'h3, 4'h9);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_early_valid: got %b expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_res !== 32'h2 || out_flags !== 4'b0000 ||
            out_tag !== 4'h9) begin
            n_fail++;
            $display("FAIL arst_first_op: got v=%b res=%h flags=%b tag=%h expected v=1 res=00000002 flags=0000 tag=9",
                     out_valid, out_res, out_flags, out_tag);
        end else begin
            $display("post-reset tag=%h res=%h flags=%b", out_tag, out_res, out_flags);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_back_to_back();
        test_stall();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
